// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - pipe_MIPS32 register file with identity-preload and dump sequencer (optional bypass: REGFILE_BYPASS_EN)
module mips_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk1,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     init_req,
  input  logic                     dump_req,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [ADDR_W-1:0]        dump_addr,
  output logic [DATA_W-1:0]        dump_data,
  output logic                     busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, INIT, DUMP} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                dump_valid_q, dump_valid_d;
  logic [ADDR_W-1:0]   dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0]   dump_data_q, dump_data_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DATA_W-1:0]   regs_d [DEPTH];

  logic                handshake;
  logic                user_wr;
  logic [ADDR_W-1:0]   next_addr;

  // A write-port write only lands outside INIT and never on a hard-wired zero entry
  assign handshake = dump_valid_q && dump_ready;
  assign user_wr   = wr_en && (state_q != INIT) && !((ZERO_REG != 0) && (wr_addr == '0));
  assign next_addr = dump_addr_q + 1'b1;

  // State register, counter, beat register and array; rst wipes everything
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= regs_d[k];
    end
  end

  // Next-state: INIT beats DUMP on simultaneous requests; requests while busy are dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (init_req)      state_d = INIT;
        else if (dump_req) state_d = DUMP;
      end
      INIT: if (cnt_q == LAST) state_d = IDLE;
      DUMP: if (handshake && (dump_addr_q == LAST)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: array update, preload counter and dump beat loading from pre-edge array
  always_comb begin
    cnt_d        = cnt_q;
    dump_valid_d = dump_valid_q;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    for (int k = 0; k < DEPTH; k++) regs_d[k] = regs_q[k];

    if (user_wr) regs_d[wr_addr] = wr_data;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!init_req && dump_req) begin
          dump_valid_d = 1'b1;
          dump_addr_d  = '0;
          dump_data_d  = regs_q[0];
        end
      end
      INIT: begin
        if (!((ZERO_REG != 0) && (cnt_q == '0))) regs_d[cnt_q] = DATA_W'(cnt_q);
        cnt_d = cnt_q + 1'b1;
      end
      DUMP: begin
        if (handshake) begin
          if (dump_addr_q == LAST) begin
            dump_valid_d = 1'b0;
          end else begin
            dump_addr_d = next_addr;
            dump_data_d = regs_q[next_addr];
          end
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign dump_valid = dump_valid_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;

  // Combinational read ports; bypass forwards an in-flight write, zero entry overrides all
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rword;

    assign ra = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rword = regs_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (user_wr && (wr_addr == ra)) rword = wr_data;
`else
`endif
      if ((ZERO_REG != 0) && (ra == '0)) rword = '0;
    end

    assign rd_data[i*DATA_W +: DATA_W] = rword;
  end

endmodule

// File: tb/tb_mips_regfile.sv
// tb/tb_mips_regfile.sv - scoreboard bench for mips_regfile
module tb_mips_regfile;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int DEPTH  = 32;

  logic                     clk1 = 1'b0;
  logic                     rst;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     init_req;
  logic                     dump_req;
  logic                     dump_valid;
  logic                     dump_ready;
  logic [ADDR_W-1:0]        dump_addr;
  logic [DATA_W-1:0]        dump_data;
  logic                     busy;

  logic [DATA_W-1:0] rd0, rd1;
  assign rd0 = rd_data[DATA_W-1:0];
  assign rd1 = rd_data[2*DATA_W-1:DATA_W];

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] model [DEPTH];
  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [DATA_W-1:0] exp_data_q [$];

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  always #5 clk1 = ~clk1;

  mips_regfile #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
  ) dut (
    .clk1(clk1), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_req(init_req), .dump_req(dump_req),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .busy(busy)
  );

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic push_model_beats();
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int k = 0; k < DEPTH; k++) begin
      exp_addr_q.push_back(ADDR_W'(k));
      exp_data_q.push_back(model[k]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; init_req = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (3) @(posedge clk1);
    #1;
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) model[k] = '0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (dump_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_dump_valid: got %b want 0", dump_valid); end
    tests_run++; if (dump_addr !== '0) begin tests_failed++; $display("FAIL reset_dump_addr: got %0d want 0", dump_addr); end
    tests_run++; if (dump_data !== '0) begin tests_failed++; $display("FAIL reset_dump_data: got %0h want 0", dump_data); end
    rd_addr = {5'd31, 5'd1};
    #1;
    tests_run++; if (rd0 !== model[1]) begin tests_failed++; $display("FAIL reset_rd_r1: got %0h want %0h", rd0, model[1]); end
    tests_run++; if (rd1 !== model[31]) begin tests_failed++; $display("FAIL reset_rd_r31: got %0h want %0h", rd1, model[31]); end
  endtask

  task automatic test_init();
    int cnt;
    tick();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    tests_run++; if (cnt != DEPTH) begin tests_failed++; $display("FAIL init_busy_cycles: got %0d want %0d", cnt, DEPTH); end
    for (int k = 0; k < DEPTH; k++) model[k] = DATA_W'(k);
    model[0] = '0;
    rd_addr = {5'd2, 5'd1};
    #1;
    tests_run++; if (rd0 !== model[1]) begin tests_failed++; $display("FAIL init_rd_r1: got %0h want %0h", rd0, model[1]); end
    tests_run++; if (rd1 !== model[2]) begin tests_failed++; $display("FAIL init_rd_r2: got %0h want %0h", rd1, model[2]); end
    rd_addr = {5'd0, 5'd31};
    #1;
    tests_run++; if (rd0 !== 32'd31) begin tests_failed++; $display("FAIL init_rd_r31: got %0h want 1f", rd0); end
    tests_run++; if (rd1 !== 32'd0) begin tests_failed++; $display("FAIL init_rd_r0: got %0h want 0", rd1); end
  endtask

  task automatic test_write_read();
    logic [DATA_W-1:0] exp;
    tick();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'd30; rd_addr = {5'd5, 5'd4};
    #1;
    exp = BYPASS ? 32'd30 : model[4];
    tests_run++; if (rd0 !== exp) begin tests_failed++; $display("FAIL same_cycle_r4: got %0h want %0h", rd0, exp); end
    tick();
    model[4] = 32'd30;
    wr_addr = 5'd5; wr_data = 32'd55;
    #1;
    exp = BYPASS ? 32'd55 : model[5];
    tests_run++; if (rd0 !== model[4]) begin tests_failed++; $display("FAIL next_cycle_r4: got %0h want %0h", rd0, model[4]); end
    tests_run++; if (rd1 !== exp) begin tests_failed++; $display("FAIL same_cycle_r5: got %0h want %0h", rd1, exp); end
    tick();
    model[5] = 32'd55;
    wr_en = 1'b0;
    #1;
    tests_run++; if (rd0 !== 32'd30) begin tests_failed++; $display("FAIL read_r4: got %0h want 1e", rd0); end
    tests_run++; if (rd1 !== 32'd55) begin tests_failed++; $display("FAIL read_r5: got %0h want 37", rd1); end
  endtask

  task automatic test_zero_reg();
    tick();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd0};
    #1;
    tests_run++; if (rd0 !== 32'd0) begin tests_failed++; $display("FAIL zero_same_cycle: got %0h want 0", rd0); end
    tick();
    wr_en = 1'b0;
    #1;
    tests_run++; if (rd0 !== 32'd0) begin tests_failed++; $display("FAIL zero_after_write_p0: got %0h want 0", rd0); end
    tests_run++; if (rd1 !== 32'd0) begin tests_failed++; $display("FAIL zero_after_write_p1: got %0h want 0", rd1); end
  endtask

  task automatic test_dump_backpressure();
    int cyc, acc;
    bit prev_stall;
    logic [ADDR_W-1:0] prev_addr, ea;
    logic [DATA_W-1:0] prev_data, ed;
    push_model_beats();
    tick();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    cyc = 0; acc = 0; prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
    while (acc < DEPTH && cyc < 200) begin
      dump_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      tests_run++; if (dump_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid cyc %0d: got %b want 1", cyc, dump_valid); end
      if (prev_stall) begin
        tests_run++; if (dump_addr !== prev_addr) begin tests_failed++; $display("FAIL bp_stall_addr: got %0d want %0d", dump_addr, prev_addr); end
        tests_run++; if (dump_data !== prev_data) begin tests_failed++; $display("FAIL bp_stall_data: got %0h want %0h", dump_data, prev_data); end
      end
      if (dump_ready && dump_valid === 1'b1) begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        tests_run++; if (dump_addr !== ea) begin tests_failed++; $display("FAIL bp_beat_addr: got %0d want %0d", dump_addr, ea); end
        tests_run++; if (dump_data !== ed) begin tests_failed++; $display("FAIL bp_beat_data addr %0d: got %0h want %0h", ea, dump_data, ed); end
        acc++;
      end
      prev_stall = !dump_ready;
      prev_addr  = dump_addr;
      prev_data  = dump_data;
      tick();
      cyc++;
    end
    dump_ready = 1'b0;
    tests_run++; if (acc != DEPTH) begin tests_failed++; $display("FAIL bp_beat_count: got %0d want %0d", acc, DEPTH); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_busy_after_last: got %b want 0", busy); end
    tests_run++; if (dump_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_valid_after_last: got %b want 0", dump_valid); end
  endtask

  task automatic test_write_during_dump();
    int cyc, acc, stall;
    bit prev_stall;
    logic [ADDR_W-1:0] prev_addr, ea;
    logic [DATA_W-1:0] prev_data, ed;
    push_model_beats();
    tick();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    cyc = 0; acc = 0; stall = 0; prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
    while (acc < DEPTH && cyc < 200) begin
      wr_en = 1'b0;
      dump_ready = 1'b1;
      if (dump_addr == 5'd3 && stall < 2) begin
        dump_ready = 1'b0;
        if (stall == 0) begin
          wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd99; model[3] = 32'd99;
        end
        stall++;
      end
      if (dump_addr == 5'd8 && dump_valid === 1'b1) begin
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'd77; model[10] = 32'd77;
        for (int i = 0; i < exp_addr_q.size(); i++)
          if (exp_addr_q[i] == 5'd10) exp_data_q[i] = 32'd77;
      end
      if (prev_stall) begin
        tests_run++; if (dump_addr !== prev_addr) begin tests_failed++; $display("FAIL wd_stall_addr: got %0d want %0d", dump_addr, prev_addr); end
        tests_run++; if (dump_data !== prev_data) begin tests_failed++; $display("FAIL wd_stall_data: got %0h want %0h", dump_data, prev_data); end
      end
      if (dump_ready && dump_valid === 1'b1) begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        tests_run++; if (dump_addr !== ea) begin tests_failed++; $display("FAIL wd_beat_addr: got %0d want %0d", dump_addr, ea); end
        tests_run++; if (dump_data !== ed) begin tests_failed++; $display("FAIL wd_beat_data addr %0d: got %0h want %0h", ea, dump_data, ed); end
        acc++;
      end
      prev_stall = (dump_valid === 1'b1) && !dump_ready;
      prev_addr  = dump_addr;
      prev_data  = dump_data;
      tick();
      cyc++;
    end
    wr_en = 1'b0;
    dump_ready = 1'b0;
    tests_run++; if (acc != DEPTH) begin tests_failed++; $display("FAIL wd_beat_count: got %0d want %0d", acc, DEPTH); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL wd_busy_after_last: got %b want 0", busy); end
    rd_addr = {5'd10, 5'd3};
    #1;
    tests_run++; if (rd0 !== model[3]) begin tests_failed++; $display("FAIL wd_read_r3: got %0h want %0h", rd0, model[3]); end
    tests_run++; if (rd1 !== model[10]) begin tests_failed++; $display("FAIL wd_read_r10: got %0h want %0h", rd1, model[10]); end
  endtask

  task automatic test_reset_mid_dump();
    int cyc, acc;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    tick();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    dump_ready = 1'b1;
    cyc = 0;
    while (dump_addr !== 5'd7 && cyc < 100) begin
      tick();
      cyc++;
    end
    tests_run++; if (dump_addr !== 5'd7) begin tests_failed++; $display("FAIL rmd_reach_beat7: got %0d want 7", dump_addr); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    dump_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) model[k] = '0;
    tests_run++; if (dump_valid !== 1'b0) begin tests_failed++; $display("FAIL rmd_valid: got %b want 0", dump_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rmd_busy: got %b want 0", busy); end
    for (int a = 0; a < DEPTH; a += 2) begin
      rd_addr = {ADDR_W'(a + 1), ADDR_W'(a)};
      #1;
      tests_run++; if (rd0 !== model[a]) begin tests_failed++; $display("FAIL rmd_read r%0d: got %0h want %0h", a, rd0, model[a]); end
      tests_run++; if (rd1 !== model[a+1]) begin tests_failed++; $display("FAIL rmd_read r%0d: got %0h want %0h", a + 1, rd1, model[a+1]); end
    end
    push_model_beats();
    tick();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    dump_ready = 1'b1;
    cyc = 0; acc = 0;
    while (acc < DEPTH && cyc < 200) begin
      if (dump_valid === 1'b1) begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        tests_run++; if (dump_addr !== ea) begin tests_failed++; $display("FAIL rmd_zero_addr: got %0d want %0d", dump_addr, ea); end
        tests_run++; if (dump_data !== ed) begin tests_failed++; $display("FAIL rmd_zero_data addr %0d: got %0h want %0h", ea, dump_data, ed); end
        acc++;
      end
      tick();
      cyc++;
    end
    dump_ready = 1'b0;
    tests_run++; if (acc != DEPTH) begin tests_failed++; $display("FAIL rmd_zero_count: got %0d want %0d", acc, DEPTH); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rmd_zero_busy: got %b want 0", busy); end
  endtask

  task automatic test_init_priority();
    int cnt;
    tick();
    init_req = 1'b1;
    dump_req = 1'b1;
    tick();
    init_req = 1'b0;
    dump_req = 1'b0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL prio_busy: got %b want 1", busy); end
    tests_run++; if (dump_valid !== 1'b0) begin tests_failed++; $display("FAIL prio_no_dump: got %b want 0", dump_valid); end
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      dump_req = (cnt == 5);
      wr_en    = (cnt == 5);
      wr_addr  = 5'd6;
      wr_data  = 32'd1234;
      tick();
      cnt++;
    end
    dump_req = 1'b0;
    wr_en = 1'b0;
    for (int k = 0; k < DEPTH; k++) model[k] = DATA_W'(k);
    model[0] = '0;
    tests_run++; if (cnt != DEPTH) begin tests_failed++; $display("FAIL prio_busy_cycles: got %0d want %0d", cnt, DEPTH); end
    tick();
    tests_run++; if (dump_valid !== 1'b0) begin tests_failed++; $display("FAIL prio_req_not_queued: got %b want 0", dump_valid); end
    rd_addr = {5'd1, 5'd6};
    #1;
    tests_run++; if (rd0 !== model[6]) begin tests_failed++; $display("FAIL prio_wr_ignored_r6: got %0h want %0h", rd0, model[6]); end
    tests_run++; if (rd1 !== model[1]) begin tests_failed++; $display("FAIL prio_init_r1: got %0h want %0h", rd1, model[1]); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_zero_reg();
    test_dump_backpressure();
    test_write_during_dump();
    test_reset_mid_dump();
    test_init_priority();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
